// File: rtl/line_buffer_7row.sv
// Raster-to-column converter: six cascaded line memories turn a raster pixel stream
// into the 7 vertically aligned pixels of the current column, with position tracking.
module line_buffer_7row #(
  parameter int unsigned DATA_W = 9,
  parameter int unsigned IMG_W  = 640,
  parameter int unsigned IMG_H  = 480,
  parameter int unsigned COL_W  = 10,
  parameter int unsigned ROW_W  = 9
) (
  input  logic              iclk,
  input  logic              irst_n,
  input  logic              ivalid,
  input  logic              isof,
  input  logic [DATA_W-1:0] idata,
  output logic [DATA_W-1:0] otap0,
  output logic [DATA_W-1:0] otap1,
  output logic [DATA_W-1:0] otap2,
  output logic [DATA_W-1:0] otap3,
  output logic [DATA_W-1:0] otap4,
  output logic [DATA_W-1:0] otap5,
  output logic [DATA_W-1:0] otap6,
  output logic              ovalid,
  output logic              owin_valid,
  output logic [COL_W-1:0]  ocol,
  output logic [ROW_W-1:0]  orow,
  output logic              oeol,
  output logic              oeof
);

  localparam int unsigned    N_LINES  = 6;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0] WIN_COL  = COL_W'(N_LINES);
  localparam logic [ROW_W-1:0] WIN_ROW  = ROW_W'(N_LINES);

  logic [DATA_W-1:0] line_mem [N_LINES][IMG_W];
  logic [COL_W-1:0]  col_cnt;
  logic [ROW_W-1:0]  row_cnt;
  logic [COL_W-1:0]  eff_col;
  logic [ROW_W-1:0]  eff_row;
  logic              at_eol;
  logic              at_eof;
  logic              in_win;

  // Start of frame overrides the counters for the current pixel.
  always_comb begin
    eff_col = col_cnt;
    eff_row = row_cnt;
    if (isof) begin
      eff_col = '0;
      eff_row = '0;
    end
    at_eol = (eff_col == LAST_COL);
    at_eof = at_eol && (eff_row == LAST_ROW);
    in_win = (eff_col >= WIN_COL) && (eff_row >= WIN_ROW);
  end

  // Cascade shift: each line takes the older contents of the line below it.
  always_ff @(posedge iclk) begin
    if (ivalid) begin
      line_mem[0][eff_col] <= idata;
      for (int k = 1; k < N_LINES; k++) begin
        line_mem[k][eff_col] <= line_mem[k-1][eff_col];
      end
    end
  end

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      col_cnt <= '0;
      row_cnt <= '0;
    end else if (ivalid) begin
      if (at_eol) begin
        col_cnt <= '0;
        row_cnt <= (eff_row == LAST_ROW) ? '0 : eff_row + ROW_W'(1);
      end else begin
        col_cnt <= eff_col + COL_W'(1);
        row_cnt <= eff_row;
      end
    end
  end

  // Taps and position hold across gaps; qualifier pulses clear.
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      otap0      <= '0;
      otap1      <= '0;
      otap2      <= '0;
      otap3      <= '0;
      otap4      <= '0;
      otap5      <= '0;
      otap6      <= '0;
      ovalid     <= 1'b0;
      owin_valid <= 1'b0;
      ocol       <= '0;
      orow       <= '0;
      oeol       <= 1'b0;
      oeof       <= 1'b0;
    end else if (ivalid) begin
      otap0      <= idata;
      otap1      <= line_mem[0][eff_col];
      otap2      <= line_mem[1][eff_col];
      otap3      <= line_mem[2][eff_col];
      otap4      <= line_mem[3][eff_col];
      otap5      <= line_mem[4][eff_col];
      otap6      <= line_mem[5][eff_col];
      ovalid     <= 1'b1;
      owin_valid <= in_win;
      ocol       <= eff_col;
      orow       <= eff_row;
      oeol       <= at_eol;
      oeof       <= at_eof;
    end else begin
      ovalid     <= 1'b0;
      owin_valid <= 1'b0;
      oeol       <= 1'b0;
      oeof       <= 1'b0;
    end
  end

endmodule
